// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the ball game blocks. Holds the
//               ball state encoding, the default arena bounds and the
//               BCD digit geometry used by the score path.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Ball state machine encoding; this value is also driven on the state port.
    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_RUN   = 2'b01,
        ST_MISS  = 2'b10
    } state_t;

    // Default arena bounds, all inclusive, in pixels.
    localparam int unsigned c_X_MIN_DEF = 2;
    localparam int unsigned c_X_MAX_DEF = 762;
    localparam int unsigned c_Y_MIN_DEF = 36;
    localparam int unsigned c_Y_MAX_DEF = 562;

    // BCD score geometry.
    localparam int unsigned c_BCD_W      = 4;
    localparam int unsigned c_BCD_DIGITS = 4;

endpackage
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter4
// Description : Four-digit BCD counter that increments by one when i_inc is
//               high, rippling the carry through the digits. It stops at
//               9999 and never wraps.
// Ports       : clk     - system clock
//               rst     - asynchronous active-low reset, clears the count
//               i_inc   - increment request for this cycle
//               o_count - registered BCD count, digit 3 in [15:12]
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter4
    import game_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_inc,
    output logic [c_BCD_DIGITS*c_BCD_W-1:0]   o_count
);

    localparam int unsigned c_W = c_BCD_DIGITS * c_BCD_W;

    logic [c_W-1:0] r_count;
    logic [c_W-1:0] w_next;
    logic           w_carry;
    logic           w_sat;

    // Ripple: each digit at 9 rolls to 0 and passes the carry upward. The
    // first digit below 9 absorbs the carry.
    always_comb begin
        w_next  = r_count;
        w_carry = 1'b1;
        for (int i = 0; i < int'(c_BCD_DIGITS); i++) begin
            if (w_carry) begin
                if (r_count[i*c_BCD_W +: c_BCD_W] == c_BCD_W'(9)) begin
                    w_next[i*c_BCD_W +: c_BCD_W] = '0;
                end else begin
                    w_next[i*c_BCD_W +: c_BCD_W] = r_count[i*c_BCD_W +: c_BCD_W] + 1'b1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    assign w_sat = (r_count == {c_BCD_DIGITS{c_BCD_W'(9)}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : ball_engine
// Description : Moves one ball inside a rectangular arena once per video
//               frame. The ball bounces off the left, right and top walls
//               and off a paddle on the bottom line. It also runs the
//               serve/run/miss sequence and keeps a saturating BCD score.
// Ports       : clk      - system clock
//               rst      - asynchronous active-low reset
//               frame    - frame marker (rising edge = one frame)
//               over     - freezes position, score and state while high
//               launch   - serve request, sampled only in SERVE
//               speed_x  - horizontal step, latched at serve (0 acts as 1)
//               speed_y  - vertical step, latched at serve (0 acts as 1)
//               paddle_x - left pixel of the paddle
//               x, y     - ball position
//               score    - 4-digit BCD score
//               miss     - one-cycle pulse when the ball passes the paddle
//               state    - 00 SERVE, 01 RUN, 10 MISS
// Revision    : 1.0 - initial release
// ============================================================================
module ball_engine
    import game_pkg::*;
#(
    parameter int unsigned X0       = 500,
    parameter int unsigned Y0       = 300,
    parameter int unsigned X_MIN    = c_X_MIN_DEF,
    parameter int unsigned X_MAX    = c_X_MAX_DEF,
    parameter int unsigned Y_MIN    = c_Y_MIN_DEF,
    parameter int unsigned Y_MAX    = c_Y_MAX_DEF,
    parameter int unsigned VW       = 3,
    parameter int unsigned PADDLE_W = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame,
    input  logic          over,
    input  logic          launch,
    input  logic [VW-1:0] speed_x,
    input  logic [VW-1:0] speed_y,
    input  logic [10:0]   paddle_x,
    output logic [10:0]   x,
    output logic [9:0]    y,
    output logic [15:0]   score,
    output logic          miss,
    output logic [1:0]    state
);

    // The 12-bit forms are used for the overshoot tests, so the sums of
    // position and step cannot wrap for any speed.
    localparam logic [10:0] c_X0       = 11'(X0);
    localparam logic [9:0]  c_Y0       = 10'(Y0);
    localparam logic [10:0] c_X_MIN11  = 11'(X_MIN);
    localparam logic [10:0] c_X_MAX11  = 11'(X_MAX);
    localparam logic [9:0]  c_Y_MIN10  = 10'(Y_MIN);
    localparam logic [9:0]  c_Y_MAX10  = 10'(Y_MAX);
    localparam logic [11:0] c_X_MIN12  = 12'(X_MIN);
    localparam logic [11:0] c_X_MAX12  = 12'(X_MAX);
    localparam logic [11:0] c_Y_MIN12  = 12'(Y_MIN);
    localparam logic [11:0] c_Y_MAX12  = 12'(Y_MAX);
    localparam logic [11:0] c_PW_M1    = 12'(PADDLE_W - 1);

    state_t        r_state, w_state_next;
    logic          r_frame_d;
    logic          r_tick;
    logic [10:0]   r_x, w_x_next, w_x_new;
    logic [9:0]    r_y, w_y_next, w_y_new;
    logic [VW-1:0] r_vx, w_vx_next;
    logic [VW-1:0] r_vy, w_vy_next;
    logic          r_dir_right, w_dir_right_next;
    logic          r_dir_up, w_dir_up_next;
    logic          r_miss, w_miss_next;
    logic          w_hit;
    logic          w_score_inc;
    logic          w_tick;
    logic [11:0]   w_vx12, w_vy12, w_px12;

    // A registered frame edge is consumed only when the game is not frozen.
    assign w_tick = r_tick && !over;
    assign w_vx12 = 12'(r_vx);
    assign w_vy12 = 12'(r_vy);
    assign w_px12 = {1'b0, paddle_x};

    always_comb begin
        w_state_next     = r_state;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_x_new          = r_x;
        w_y_new          = r_y;
        w_vx_next        = r_vx;
        w_vy_next        = r_vy;
        w_dir_right_next = r_dir_right;
        w_dir_up_next    = r_dir_up;
        w_miss_next      = 1'b0;
        w_hit            = 1'b0;
        w_score_inc      = 1'b0;

        case (r_state)
            ST_SERVE: begin
                w_x_next = c_X0;
                w_y_next = c_Y0;
                if (launch && !over) begin
                    w_vx_next        = (speed_x == '0) ? VW'(1) : speed_x;
                    w_vy_next        = (speed_y == '0) ? VW'(1) : speed_y;
                    w_dir_right_next = 1'b1;
                    w_dir_up_next    = 1'b1;
                    w_state_next     = ST_RUN;
                end
            end

            ST_RUN: begin
                if (w_tick) begin
                    if (r_dir_right) begin
                        if (({1'b0, r_x} + w_vx12) > c_X_MAX12) begin
                            w_x_new          = c_X_MAX11;
                            w_dir_right_next = 1'b0;
                            w_hit            = 1'b1;
                        end else begin
                            w_x_new = r_x + 11'(r_vx);
                        end
                    end else begin
                        if ({1'b0, r_x} < (c_X_MIN12 + w_vx12)) begin
                            w_x_new          = c_X_MIN11;
                            w_dir_right_next = 1'b1;
                            w_hit            = 1'b1;
                        end else begin
                            w_x_new = r_x - 11'(r_vx);
                        end
                    end

                    if (r_dir_up) begin
                        if ({2'b00, r_y} < (c_Y_MIN12 + w_vy12)) begin
                            w_y_new       = c_Y_MIN10;
                            w_dir_up_next = 1'b0;
                            w_hit         = 1'b1;
                        end else begin
                            w_y_new = r_y - 10'(r_vy);
                        end
                    end else begin
                        if (({2'b00, r_y} + w_vy12) > c_Y_MAX12) begin
                            // Bottom line: the paddle is tested against the
                            // horizontal position this same tick produces.
                            w_y_new = c_Y_MAX10;
                            if (({1'b0, w_x_new} >= w_px12) &&
                                ({1'b0, w_x_new} <= (w_px12 + c_PW_M1))) begin
                                w_dir_up_next = 1'b1;
                                w_hit         = 1'b1;
                            end else begin
                                w_miss_next  = 1'b1;
                                w_state_next = ST_MISS;
                            end
                        end else begin
                            w_y_new = r_y + 10'(r_vy);
                        end
                    end

                    w_x_next = w_x_new;
                    w_y_next = w_y_new;
                    // One point per tick however many walls were touched,
                    // and none on the tick the ball is lost.
                    w_score_inc = w_hit && !w_miss_next;
                end
            end

            ST_MISS: begin
                if (w_tick) begin
                    w_state_next = ST_SERVE;
                    w_x_next     = c_X0;
                    w_y_next     = c_Y0;
                end
            end

            default: begin
                w_state_next = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_d   <= 1'b0;
            r_tick      <= 1'b0;
            r_state     <= ST_SERVE;
            r_x         <= c_X0;
            r_y         <= c_Y0;
            r_vx        <= VW'(1);
            r_vy        <= VW'(1);
            r_dir_right <= 1'b1;
            r_dir_up    <= 1'b1;
            r_miss      <= 1'b0;
        end else begin
            // The edge detector runs regardless of over, so releasing over
            // while frame is already high does not produce a tick.
            r_frame_d   <= frame;
            r_tick      <= frame && !r_frame_d;
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_vx        <= w_vx_next;
            r_vy        <= w_vy_next;
            r_dir_right <= w_dir_right_next;
            r_dir_up    <= w_dir_up_next;
            r_miss      <= w_miss_next;
        end
    end

    bcd_counter4 u_score (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_score_inc),
        .o_count (score)
    );

    assign x     = r_x;
    assign y     = r_y;
    assign miss  = r_miss;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_engine
// Description : Self-checking bench for ball_engine. Two instances: the
//               default arena under random stimulus, and a tiny arena with a
//               full-width paddle where every frame scores, used to reach the
//               0999->1000 carry and the 9999 ceiling. A frame-level model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: default arena
    logic        rst, frame, over, launch;
    logic [2:0]  speed_x, speed_y;
    logic [10:0] paddle_x;
    logic [10:0] x;
    logic [9:0]  y;
    logic [15:0] score;
    logic        miss;
    logic [1:0]  state;

    // Instance 2: 3x3 arena, paddle covers every x
    logic        rst2, frame2, launch2;
    logic        over2 = 1'b0;
    logic [2:0]  speed2 = 3'd7;
    logic [10:0] paddle2 = 11'd0;
    logic [10:0] x2;
    logic [9:0]  y2;
    logic [15:0] score2;
    logic        miss2;
    logic [1:0]  state2;

    ball_engine dut (
        .clk(clk), .rst(rst), .frame(frame), .over(over), .launch(launch),
        .speed_x(speed_x), .speed_y(speed_y), .paddle_x(paddle_x),
        .x(x), .y(y), .score(score), .miss(miss), .state(state)
    );

    ball_engine #(
        .X0(3), .Y0(37), .X_MIN(2), .X_MAX(4), .Y_MIN(36), .Y_MAX(38),
        .VW(3), .PADDLE_W(2047)
    ) dut2 (
        .clk(clk), .rst(rst2), .frame(frame2), .over(over2), .launch(launch2),
        .speed_x(speed2), .speed_y(speed2), .paddle_x(paddle2),
        .x(x2), .y(y2), .score(score2), .miss(miss2), .state(state2)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int x, y, score, vx, vy, st;   // st: 0 serve, 1 run, 2 miss
        bit dr, du, miss, fd, tk;      // dr: moving right, du: moving up
    } mdl_t;

    mdl_t m1, m2;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk1 = 1'b0;
    bit  chk2 = 1'b0;

    function automatic mdl_t mreset(int x0, int y0);
        mdl_t m;
        m.x = x0; m.y = y0; m.score = 0; m.vx = 1; m.vy = 1; m.st = 0;
        m.dr = 1'b1; m.du = 1'b1; m.miss = 1'b0; m.fd = 1'b0; m.tk = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit fr, bit ov, bit la, int sx, int sy, int px,
                                   int x0, int y0, int xmn, int xmx, int ymn, int ymx, int pw);
        mdl_t n;
        bit   hit;
        n      = m;
        hit    = 1'b0;
        n.fd   = fr;
        n.tk   = fr && !m.fd;
        n.miss = 1'b0;
        if (!ov) begin
            if (m.st == 0) begin
                n.x = x0; n.y = y0;
                if (la) begin
                    n.vx = (sx == 0) ? 1 : sx;
                    n.vy = (sy == 0) ? 1 : sy;
                    n.dr = 1'b1; n.du = 1'b1; n.st = 1;
                end
            end else if (m.st == 1 && m.tk) begin
                if (m.dr) begin
                    if (m.x + m.vx > xmx) begin n.x = xmx; n.dr = 1'b0; hit = 1'b1; end
                    else n.x = m.x + m.vx;
                end else begin
                    if (m.x < xmn + m.vx) begin n.x = xmn; n.dr = 1'b1; hit = 1'b1; end
                    else n.x = m.x - m.vx;
                end
                if (m.du) begin
                    if (m.y < ymn + m.vy) begin n.y = ymn; n.du = 1'b0; hit = 1'b1; end
                    else n.y = m.y - m.vy;
                end else if (m.y + m.vy > ymx) begin
                    n.y = ymx;
                    if (n.x >= px && n.x <= px + pw - 1) begin n.du = 1'b1; hit = 1'b1; end
                    else begin n.miss = 1'b1; n.st = 2; hit = 1'b0; end
                end else begin
                    n.y = m.y + m.vy;
                end
                if (hit && n.score < 9999) n.score = n.score + 1;
            end else if (m.st == 2 && m.tk) begin
                n.st = 0; n.x = x0; n.y = y0;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m1 = mreset(500, 300);
        else      m1 = mstep(m1, frame, over, launch, int'(speed_x), int'(speed_y),
                             int'(paddle_x), 500, 300, 2, 762, 36, 562, 96);
    end

    always @(posedge clk or negedge rst2) begin
        if (!rst2) m2 = mreset(3, 37);
        else       m2 = mstep(m2, frame2, over2, launch2, int'(speed2), int'(speed2),
                              int'(paddle2), 3, 37, 2, 4, 36, 38, 2047);
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [10:0] ax, logic [9:0] ay, logic [15:0] as,
                       logic am, logic [1:0] ast, mdl_t m);
        logic [15:0] es;
        es = to_bcd(m.score);
        n_tests++;
        if (ax !== 11'(m.x) || ay !== 10'(m.y) || as !== es || am !== m.miss || ast !== 2'(m.st)) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d y=%0d score=%h miss=%0b state=%0d, want x=%0d y=%0d score=%h miss=%0b state=%0d",
                     nm, $time, ax, ay, as, am, ast, m.x, m.y, es, m.miss, m.st);
        end
    endtask

    task automatic lit(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk1 && rst)  chk("model_dut1", x, y, score, miss, state, m1);
        if (chk2 && rst2) chk("model_dut2", x2, y2, score2, miss2, state2, m2);
    end

    // ---------------- stimulus ----------------
    task automatic do_edge();
        frame = 1'b1;
        repeat (3) @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
    endtask

    task automatic stim1();
        int t;
        rst = 1'b0; frame = 1'b0; over = 1'b0; launch = 1'b0;
        speed_x = 3'd0; speed_y = 3'd0; paddle_x = 11'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1 = 1'b1;
        lit("reset_x", int'(x), 500);
        lit("reset_y", int'(y), 300);
        lit("reset_state", int'(state), 0);
        lit("reset_score", int'(score), 0);
        lit("reset_miss", int'(miss), 0);

        speed_x = 3'd2; speed_y = 3'd2; launch = 1'b1;
        @(negedge clk);
        launch = 1'b0; speed_x = 3'd5; speed_y = 3'd6;
        @(negedge clk);
        lit("launch_state", int'(state), 1);
        lit("launch_x_held", int'(x), 500);
        do_edge();
        lit("first_tick_x", int'(x), 502);
        lit("first_tick_y", int'(y), 298);

        over = 1'b1;
        repeat (5) do_edge();
        lit("over_x", int'(x), 502);
        lit("over_y", int'(y), 298);
        lit("over_score", int'(score), 0);
        frame = 1'b1;
        repeat (2) @(negedge clk);
        over = 1'b0;
        repeat (3) @(negedge clk);
        lit("release_no_tick_x", int'(x), 502);
        frame = 1'b0;
        @(negedge clk);
        do_edge();
        lit("after_release_x", int'(x), 504);
        lit("after_release_y", int'(y), 296);

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (i == 10000) begin
                #2 rst = 1'b0;
                #1;
                lit("async_reset_x", int'(x), 500);
                lit("async_reset_y", int'(y), 300);
                lit("async_reset_score", int'(score), 0);
                lit("async_reset_state", int'(state), 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
            end
            if ($urandom_range(0, 1) == 0) frame = ~frame;
            over    = ($urandom_range(0, 19) == 0);
            launch  = ($urandom_range(0, 3) == 0);
            speed_x = 3'($urandom_range(0, 7));
            speed_y = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                t = m1.x - int'($urandom_range(0, 100));
                paddle_x = (t < 0) ? 11'd0 : 11'(t);
            end else begin
                paddle_x = 11'($urandom_range(0, 800));
            end
        end
    endtask

    task automatic stim2();
        int k;
        rst2 = 1'b0; frame2 = 1'b0; launch2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        chk2 = 1'b1;
        launch2 = 1'b1;
        @(negedge clk);
        launch2 = 1'b0;
        k = 0;
        while (m2.score < 1000 && k < 30000) begin
            frame2 = ~frame2;
            @(negedge clk);
            k++;
        end
        lit("dut2_reach_1000_in_budget", (k < 30000) ? 1 : 0, 1);
        lit("score_0999_to_1000", int'(score2), 'h1000);
        while (m2.score < 9999 && k < 60000) begin
            frame2 = ~frame2;
            @(negedge clk);
            k++;
        end
        lit("dut2_reach_9999_in_budget", (k < 60000) ? 1 : 0, 1);
        repeat (40) begin
            frame2 = ~frame2;
            @(negedge clk);
        end
        lit("score_saturates_9999", int'(score2), 'h9999);
        lit("dut2_still_running", int'(state2), 1);
    endtask

    initial begin
        fork
            stim1();
            stim2();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
